// File: rtl/sdram_req_bridge_if.sv
// Client-side byte buses and SDRAM toggle-handshake port for sdram_req_bridge.
interface sdram_req_bridge_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 16,
    parameter int DW     = 8
);
    logic [NPORTS-1:0]    port_cs;
    logic [NPORTS-1:0]    port_oe;
    logic [NPORTS-1:0]    port_we;
    logic [NPORTS*AW-1:0] port_a;
    logic [NPORTS*DW-1:0] port_d;
    logic [NPORTS*DW-1:0] port_q;
    logic [NPORTS-1:0]    port_busy;
    logic [NPORTS-1:0]    port_err;

    logic                 mem_req;
    logic                 mem_ack;
    logic [AW-1:0]        mem_a;
    logic [1:0]           mem_ds;
    logic                 mem_we;
    logic [2*DW-1:0]      mem_d;
    logic [2*DW-1:0]      mem_q;

    modport slave (
        input  port_cs, port_oe, port_we, port_a, port_d, mem_ack, mem_q,
        output port_q, port_busy, port_err, mem_req, mem_a, mem_ds, mem_we, mem_d
    );

    modport master (
        output port_cs, port_oe, port_we, port_a, port_d, mem_ack, mem_q,
        input  port_q, port_busy, port_err, mem_req, mem_a, mem_ds, mem_we, mem_d
    );
endinterface

// File: rtl/sdram_req_bridge.sv
// Round-robin bridge from byte-wide client buses onto one toggle-handshake SDRAM port.
// Build option: SDRAM_BRIDGE_ADDRCHG_EN makes an address change under a held read strobe a new read.
//
// state  | meaning
// S_IDLE | no transfer outstanding; issue the next pending slot
// S_WAIT | request toggled, waiting for ack match or timeout
// S_DONE | retire the in-flight port; one dead cycle between transfers
module sdram_req_bridge #(
    parameter int NPORTS  = 2,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    sdram_req_bridge_if.slave bus
);
    localparam int              GW       = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [15:0]     TMR_LOAD = 16'(TIMEOUT - 1);
    localparam logic [GW-1:0]   LAST_RST = GW'(NPORTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [NPORTS-1:0]         pend_q, pend_d;
    logic [NPORTS-1:0]         infl_q, infl_d;
    logic [NPORTS-1:0]         err_q, err_d;
    logic [NPORTS-1:0]         oe_prev_q, oe_prev_d;
    logic [NPORTS-1:0]         we_prev_q, we_prev_d;
    logic [NPORTS-1:0][AW-1:0] slot_a_q, slot_a_d;
    logic [NPORTS-1:0][DW-1:0] slot_d_q, slot_d_d;
    logic [NPORTS-1:0]         slot_we_q, slot_we_d;
    logic [NPORTS-1:0][DW-1:0] q_q, q_d;
    logic [GW-1:0]             last_q, last_d;
    logic [GW-1:0]             gnt_q, gnt_d;
    logic [15:0]               tmr_q, tmr_d;
    logic                      req_q, req_d;
    logic [AW-1:0]             mem_a_q, mem_a_d;
    logic [1:0]                mem_ds_q, mem_ds_d;
    logic                      mem_we_q, mem_we_d;
    logic [2*DW-1:0]           mem_d_q, mem_d_d;

    logic [NPORTS-1:0]         rd_ev, wr_ev, ev, iss_vec;
    logic [GW-1:0]             pick, cand;
    logic                      pick_vld;

`ifdef SDRAM_BRIDGE_ADDRCHG_EN
    logic [NPORTS-1:0][AW-1:0] a_prev_q, a_prev_d;

    assign a_prev_d = bus.port_a;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) a_prev_q <= '0;
        else          a_prev_q <= a_prev_d;
    end
`endif

    always_comb begin
        oe_prev_d = bus.port_cs & bus.port_oe;
        we_prev_d = bus.port_cs & bus.port_we;
        rd_ev     = oe_prev_d & ~oe_prev_q;
        wr_ev     = we_prev_d & ~we_prev_q;
`ifdef SDRAM_BRIDGE_ADDRCHG_EN
        for (int i = 0; i < NPORTS; i++) begin
            if (oe_prev_d[i] && oe_prev_q[i] && (bus.port_a[i*AW +: AW] != a_prev_q[i]))
                rd_ev[i] = 1'b1;
        end
`endif
        ev = rd_ev | wr_ev;
    end

    // Scan downwards so the nearest pending port after last_q is the one that sticks.
    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            cand = GW'((int'(last_q) + k) % NPORTS);
            if (pend_q[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        infl_d    = infl_q;
        err_d     = err_q;
        slot_a_d  = slot_a_q;
        slot_d_d  = slot_d_q;
        slot_we_d = slot_we_q;
        q_d       = q_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        tmr_d     = tmr_q;
        req_d     = req_q;
        mem_a_d   = mem_a_q;
        mem_ds_d  = mem_ds_q;
        mem_we_d  = mem_we_q;
        mem_d_d   = mem_d_q;
        iss_vec   = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    iss_vec[pick] = 1'b1;
                    gnt_d         = pick;
                    last_d        = pick;
                    mem_a_d       = slot_a_q[pick];
                    mem_we_d      = slot_we_q[pick];
                    mem_d_d       = {2{slot_d_q[pick]}};
                    mem_ds_d      = slot_we_q[pick] ? (slot_a_q[pick][0] ? 2'b10 : 2'b01) : 2'b11;
                    req_d         = ~req_q;
                    pend_d[pick]  = 1'b0;
                    infl_d[pick]  = 1'b1;
                    tmr_d         = TMR_LOAD;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_ack == req_q) begin
                    if (!mem_we_q)
                        q_d[gnt_q] = mem_a_q[0] ? bus.mem_q[2*DW-1:DW] : bus.mem_q[DW-1:0];
                    state_d = S_DONE;
                end else if (tmr_q == '0) begin
                    err_d[gnt_q] = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_DONE: begin
                infl_d[gnt_q] = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A slot being issued this cycle is free to refill without flagging overrun.
        for (int i = 0; i < NPORTS; i++) begin
            if (ev[i]) begin
                if (pend_q[i] && !iss_vec[i])
                    err_d[i] = 1'b1;
                pend_d[i]    = 1'b1;
                slot_a_d[i]  = bus.port_a[i*AW +: AW];
                slot_d_d[i]  = bus.port_d[i*DW +: DW];
                slot_we_d[i] = wr_ev[i];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            infl_q    <= '0;
            err_q     <= '0;
            oe_prev_q <= '0;
            we_prev_q <= '0;
            slot_a_q  <= '0;
            slot_d_q  <= '0;
            slot_we_q <= '0;
            q_q       <= '0;
            last_q    <= LAST_RST;
            gnt_q     <= '0;
            tmr_q     <= '0;
            req_q     <= 1'b0;
            mem_a_q   <= '0;
            mem_ds_q  <= 2'b11;
            mem_we_q  <= 1'b0;
            mem_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            infl_q    <= infl_d;
            err_q     <= err_d;
            oe_prev_q <= oe_prev_d;
            we_prev_q <= we_prev_d;
            slot_a_q  <= slot_a_d;
            slot_d_q  <= slot_d_d;
            slot_we_q <= slot_we_d;
            q_q       <= q_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            tmr_q     <= tmr_d;
            req_q     <= req_d;
            mem_a_q   <= mem_a_d;
            mem_ds_q  <= mem_ds_d;
            mem_we_q  <= mem_we_d;
            mem_d_q   <= mem_d_d;
        end
    end

    assign bus.port_q    = q_q;
    assign bus.port_busy = pend_q | infl_q;
    assign bus.port_err  = err_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_ds    = mem_ds_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_d     = mem_d_q;
endmodule

// File: tb/tb_sdram_req_bridge.sv
// Directed bench for sdram_req_bridge: two ports, TIMEOUT of 8, scripted SDRAM ack responder.
module tb_sdram_req_bridge;
    localparam int NP = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    sdram_req_bridge_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

    sdram_req_bridge #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic        ack_en;
    int          ack_delay;
    logic [15:0] q_val;
    int          n_req = 0;
    logic        req_seen = 1'b0;
    logic [15:0] log_a[$];
    logic [15:0] log_d[$];
    logic [1:0]  log_ds[$];
    logic        log_we[$];
    int          base;
    int          exp_ac;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #3;
    endtask

    task automatic set_port(input int p, input logic cs, input logic oe, input logic we,
                            input logic [15:0] a, input logic [7:0] d);
        bus.port_cs[p]          = cs;
        bus.port_oe[p]          = oe;
        bus.port_we[p]          = we;
        bus.port_a[p*AW +: AW]  = a;
        bus.port_d[p*DW +: DW]  = d;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        step();
        while (bus.port_busy != '0 && n < max_cyc) begin
            step();
            n++;
        end
        check("wait_idle", 32'(bus.port_busy), 32'd0);
    endtask

    // SDRAM controller model: answers a request toggle after ack_delay cycles.
    initial begin : responder
        int cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_q   = '0;
        forever begin
            @(posedge clk_sys);
            #2;
            if (ack_en && reset_n && (bus.mem_req !== bus.mem_ack)) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    bus.mem_q   = q_val;
                    bus.mem_ack = bus.mem_req;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge clk_sys);
            #1;
            if (bus.mem_req !== req_seen) begin
                req_seen = bus.mem_req;
                n_req++;
                log_a.push_back(bus.mem_a);
                log_d.push_back(bus.mem_d);
                log_ds.push_back(bus.mem_ds);
                log_we.push_back(bus.mem_we);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset_n      = 1'b0;
        ack_en       = 1'b1;
        ack_delay    = 2;
        q_val        = '0;
        bus.port_cs  = '0;
        bus.port_oe  = '0;
        bus.port_we  = '0;
        bus.port_a   = '0;
        bus.port_d   = '0;
        repeat (3) @(posedge clk_sys);
        #3;
        check("rst_req",  32'(bus.mem_req),   32'd0);
        check("rst_we",   32'(bus.mem_we),    32'd0);
        check("rst_ds",   32'(bus.mem_ds),    32'd3);
        check("rst_a",    32'(bus.mem_a),     32'd0);
        check("rst_d",    32'(bus.mem_d),     32'd0);
        check("rst_q",    32'(bus.port_q),    32'd0);
        check("rst_busy", 32'(bus.port_busy), 32'd0);
        check("rst_err",  32'(bus.port_err),  32'd0);
        reset_n = 1'b1;
        step();

        // single read, ack two cycles after the request
        q_val = 16'hAB12;
        set_port(0, 1'b1, 1'b1, 1'b0, 16'h1235, 8'h00);
        step();
        check("rd_busy_e",   32'(bus.port_busy[0]), 32'd1);
        check("rd_req_pre",  32'(bus.mem_req),      32'd0);
        step();
        check("rd_req",      32'(bus.mem_req),      32'd1);
        check("rd_ds",       32'(bus.mem_ds),       32'd3);
        check("rd_a",        32'(bus.mem_a),        32'h1235);
        check("rd_we",       32'(bus.mem_we),       32'd0);
        step();
        step();
        check("rd_busy_k",   32'(bus.port_busy[0]), 32'd1);
        step();
        check("rd_busy_end", 32'(bus.port_busy[0]), 32'd0);
        check("rd_q",        32'(bus.port_q[7:0]),  32'hAB);
        set_port(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);

        // byte write from port 1
        base  = n_req;
        q_val = 16'hFFFF;
        set_port(1, 1'b1, 1'b0, 1'b1, 16'h0040, 8'h5A);
        step();
        step();
        check("wr_we", 32'(bus.mem_we), 32'd1);
        check("wr_ds", 32'(bus.mem_ds), 32'd1);
        check("wr_d",  32'(bus.mem_d),  32'h5A5A);
        check("wr_a",  32'(bus.mem_a),  32'h0040);
        wait_idle(20);
        check("wr_one_req", 32'(n_req - base),      32'd1);
        check("wr_no_q",    32'(bus.port_q[15:8]),  32'd0);
        set_port(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();

        // round robin: both ports fire together three times
        log_a.delete(); log_d.delete(); log_ds.delete(); log_we.delete();
        base  = n_req;
        q_val = 16'h7788;
        for (int r = 0; r < 3; r++) begin
            set_port(0, 1'b1, 1'b1, 1'b0, 16'h0200, 8'h00);
            set_port(1, 1'b1, 1'b1, 1'b0, 16'h0301, 8'h00);
            wait_idle(40);
            set_port(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            set_port(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
            step();
        end
        check("rr_count", 32'(n_req - base), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("rr_grant%0d", k), 32'(log_a[k]), (k % 2 == 0) ? 32'h0200 : 32'h0301);
        check("rr_q", 32'(bus.port_q), 32'h7788);

        // overrun: two port-0 writes while port 1 is in flight
        log_a.delete(); log_d.delete(); log_ds.delete(); log_we.delete();
        base      = n_req;
        ack_delay = 5;
        q_val     = 16'h00C3;
        set_port(1, 1'b1, 1'b1, 1'b0, 16'h0500, 8'h00);
        step();
        set_port(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_port(0, 1'b1, 1'b0, 1'b1, 16'h0011, 8'h11);
        step();
        set_port(0, 1'b1, 1'b0, 1'b0, 16'h0011, 8'h11);
        step();
        set_port(0, 1'b1, 1'b0, 1'b1, 16'h0013, 8'h22);
        step();
        check("ovr_err",   32'(bus.port_err),     32'd1);
        check("ovr_busy1", 32'(bus.port_busy[1]), 32'd1);
        set_port(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_idle(40);
        check("ovr_count", 32'(n_req - base),     32'd2);
        check("ovr_a",     32'(log_a[1]),         32'h0013);
        check("ovr_d",     32'(log_d[1]),         32'h2222);
        check("ovr_ds",    32'(log_ds[1]),        32'd2);
        check("ovr_we",    32'(log_we[1]),        32'd1);
        check("ovr_q1",    32'(bus.port_q[15:8]), 32'hC3);

        // timeout: ack withheld on a port-1 read
        ack_en = 1'b0;
        set_port(1, 1'b1, 1'b1, 1'b0, 16'h0600, 8'h00);
        step();
        set_port(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (8) step();
        check("to_err_pre",  32'(bus.port_err[1]),  32'd0);
        check("to_busy_pre", 32'(bus.port_busy[1]), 32'd1);
        step();
        check("to_err",      32'(bus.port_err[1]),  32'd1);
        step();
        check("to_busy_end", 32'(bus.port_busy[1]), 32'd0);
        check("to_q_hold",   32'(bus.port_q[15:8]), 32'hC3);
        ack_en    = 1'b1;
        ack_delay = 1;
        step();
        step();
        q_val = 16'h5AA5;
        set_port(1, 1'b1, 1'b1, 1'b0, 16'h0701, 8'h00);
        wait_idle(30);
        check("to_next_q",   32'(bus.port_q[15:8]), 32'h5A);
        check("to_err_keep", 32'(bus.port_err),     32'd3);
        set_port(1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();

        // address change with oe held
        base  = n_req;
        q_val = 16'h1111;
`ifdef SDRAM_BRIDGE_ADDRCHG_EN
        exp_ac = 2;
`else
        exp_ac = 1;
`endif
        set_port(0, 1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
        wait_idle(30);
        bus.port_a[15:0] = 16'h0101;
        wait_idle(30);
        step();
        step();
        check("addrchg_reqs", 32'(n_req - base), 32'(exp_ac));
        set_port(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();

        // strobes with cs low are ignored
        base = n_req;
        set_port(0, 1'b0, 1'b1, 1'b1, 16'h0900, 8'h99);
        step();
        step();
        check("cs_low_busy", 32'(bus.port_busy), 32'd0);
        check("cs_low_reqs", 32'(n_req - base),  32'd0);
        set_port(0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
